// File: rtl/bullet_controller.sv
// Bullet slot manager: spawns bullets into a fixed 8-entry table and steps them once per frame_tick.
// Define BULLET_CTRL_WRAP_EN to wrap positions modulo 256 instead of retiring off-screen bullets.
module bullet_controller #(
  parameter int         NSLOT = 8,
  parameter logic [7:0] BSIZE = 8'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        spawn_req,
  input  logic [15:0] spawn_pos,
  input  logic [1:0]  spawn_dir,
  input  logic [1:0]  spawn_color,
  output logic        spawn_ack,
  output logic        wr_en,
  output logic [2:0]  wr_index,
  output logic [63:0] wr_data,
  output logic        busy,
  output logic        full,
  output logic [3:0]  active_cnt,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [1:0] {CLEAR, IDLE, SPAWN, UPDATE} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    pending;
  logic [NSLOT-1:0][15:0]  pos;
  logic [NSLOT-1:0][1:0]   dir;
  logic [NSLOT-1:0][1:0]   color;
  logic [NSLOT-1:0]        active;

  logic [NSLOT-1:0][15:0]  step_pos;
  logic [NSLOT-1:0]        step_ok;

  function automatic logic [63:0] pack(input logic [15:0] p, input logic [1:0] c, input logic r);
    return {29'd0, r, c, BSIZE, BSIZE, p};
  endfunction

  // Every slot computes its next position in parallel; the FSM picks one per cycle.
  for (genvar i = 0; i < NSLOT; i++) begin : g_step
    logic [8:0] xs, ys;  // bit 8 flags a borrow below 0 or carry past 255
    always_comb begin
      xs = {1'b0, pos[i][15:8]};
      ys = {1'b0, pos[i][7:0]};
      unique case (dir[i])
        2'b00:   ys = ys + 9'd1;
        2'b01:   ys = ys - 9'd1;
        2'b10:   xs = xs + 9'd1;
        default: xs = xs - 9'd1;
      endcase
    end
`ifdef BULLET_CTRL_WRAP_EN
    assign step_ok[i]  = 1'b1;
`else
    assign step_ok[i]  = ~(xs[8] | ys[8]);
`endif
    assign step_pos[i] = step_ok[i] ? {xs[7:0], ys[7:0]} : pos[i];
  end

  logic [2:0] free_idx;
  always_comb begin
    free_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--)
      if (!active[i]) free_idx = i[2:0];
  end

  logic [2:0] vi;
  logic       go_update, visit, accept;
  assign vi        = cnt[2:0];
  assign full      = (active_cnt == 4'd8);
  assign go_update = (state == IDLE) && (frame_tick || pending);
  assign visit     = go_update || ((state == UPDATE) && !cnt[3]);
  assign accept    = (state == IDLE) && !go_update && spawn_req && !full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      cnt        <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      pos        <= '0;
      dir        <= '0;
      color      <= '0;
      active     <= '0;
      active_cnt <= '0;
      busy       <= 1'b1;
      wr_en      <= 1'b0;
      wr_index   <= '0;
      wr_data    <= '0;
      spawn_ack  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      spawn_ack  <= 1'b0;
      frame_done <= 1'b0;
      if (frame_tick && pending)       overrun <= 1'b1;
      if (frame_tick && state != IDLE) pending <= 1'b1;

      if (visit) begin
        wr_en    <= active[vi];
        wr_index <= vi;
        wr_data  <= pack(step_pos[vi], color[vi], step_ok[vi]);
        if (active[vi]) begin
          pos[vi] <= step_pos[vi];
          if (!step_ok[vi]) begin
            active[vi] <= 1'b0;
            active_cnt <= active_cnt - 4'd1;
          end
        end
      end

      unique case (state)
        CLEAR:
          if (cnt[3]) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            wr_en    <= 1'b1;
            wr_index <= vi;
            wr_data  <= '0;
            cnt      <= cnt + 4'd1;
          end
        IDLE:
          if (go_update) begin
            pending <= 1'b0;
            state   <= UPDATE;
            busy    <= 1'b1;
            cnt     <= 4'd1;
          end else if (accept) begin
            pos[free_idx]    <= spawn_pos;
            dir[free_idx]    <= spawn_dir;
            color[free_idx]  <= spawn_color;
            active[free_idx] <= 1'b1;
            active_cnt       <= active_cnt + 4'd1;
            wr_en            <= 1'b1;
            wr_index         <= free_idx;
            wr_data          <= pack(spawn_pos, spawn_color, 1'b1);
            spawn_ack        <= 1'b1;
            state            <= SPAWN;
            busy             <= 1'b1;
          end
        SPAWN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        UPDATE:
          if (cnt[3]) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: slot-level reference model checked every cycle plus literal spot checks.
module tb_bullet_controller;

  logic        clk = 1'b0;
  logic        reset, frame_tick, spawn_req;
  logic [15:0] spawn_pos;
  logic [1:0]  spawn_dir, spawn_color;
  logic        spawn_ack, wr_en, busy, full, frame_done, overrun;
  logic [2:0]  wr_index;
  logic [63:0] wr_data;
  logic [3:0]  active_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bullet_controller dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .spawn_req(spawn_req), .spawn_pos(spawn_pos), .spawn_dir(spawn_dir), .spawn_color(spawn_color),
    .spawn_ack(spawn_ack), .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
    .busy(busy), .full(full), .active_cnt(active_cnt), .frame_done(frame_done), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expire(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: no response within cycle budget (t=%0t)", nm, $time);
  endtask

  // ---------------- reference model: bullets as plain integer coordinates ----------------
  typedef struct { int x; int y; int d; int c; bit act; } mslot_t;
  mslot_t      ms[8];
  int          m_clear = 0;   // table-clear writes issued so far; 9 once the clear has finished
  int          m_upd   = -1;  // next slot of a running frame pass, -1 when none
  bit          m_spawn, m_pend;
  bit          e_wr_en, e_ack, e_fd, e_ovr;
  bit          e_busy = 1'b1;
  int          e_idx;
  logic [63:0] e_data = '0;

  function automatic logic [63:0] rec(input int x, input int y, input int c, input bit r);
    logic [63:0] v;
    v = '0;
    v[15:8]  = x[7:0];
    v[7:0]   = y[7:0];
    v[23:16] = 8'd4;
    v[31:24] = 8'd4;
    v[33:32] = c[1:0];
    v[34]    = r;
    return v;
  endfunction

  function automatic int n_act();
    int n = 0;
    for (int i = 0; i < 8; i++) if (ms[i].act) n++;
    return n;
  endfunction

  task automatic m_visit(input int k);
    int nx, ny;
    e_idx   = k;
    e_wr_en = ms[k].act;
    if (!ms[k].act) return;
    nx = ms[k].x;
    ny = ms[k].y;
    case (ms[k].d)
      0: ny = ny + 1;
      1: ny = ny - 1;
      2: nx = nx + 1;
      default: nx = nx - 1;
    endcase
`ifdef BULLET_CTRL_WRAP_EN
    nx = (nx + 256) % 256;
    ny = (ny + 256) % 256;
`else
    if (nx < 0 || nx > 255 || ny < 0 || ny > 255) begin
      ms[k].act = 1'b0;
      e_data    = rec(ms[k].x, ms[k].y, ms[k].c, 1'b0);
      return;
    end
`endif
    ms[k].x = nx;
    ms[k].y = ny;
    e_data  = rec(nx, ny, ms[k].c, 1'b1);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) ms[i] = '{0, 0, 0, 0, 1'b0};
      m_clear = 0; m_upd = -1; m_spawn = 0; m_pend = 0;
      e_wr_en = 0; e_ack = 0; e_fd = 0; e_ovr = 0; e_busy = 1; e_idx = 0; e_data = '0;
    end else begin
      bit idle0, go;
      int f;
      idle0 = (m_clear == 9) && (m_upd < 0) && !m_spawn;
      e_wr_en = 0; e_ack = 0; e_fd = 0;
      if (frame_tick && m_pend) e_ovr = 1;
      if (frame_tick && !idle0) m_pend = 1;
      go = idle0 && (frame_tick || m_pend);
      if (m_clear < 8) begin
        e_wr_en = 1; e_idx = m_clear; e_data = '0; m_clear++;
      end else if (m_clear == 8) begin
        m_clear = 9;
      end else if (go) begin
        m_pend = 0; m_visit(0); m_upd = 1;
      end else if (m_upd == 8) begin
        e_fd = 1; m_upd = -1;
      end else if (m_upd > 0) begin
        m_visit(m_upd); m_upd++;
      end else if (m_spawn) begin
        m_spawn = 0;
      end else if (idle0 && spawn_req && n_act() < 8) begin
        f = -1;
        for (int i = 7; i >= 0; i--) if (!ms[i].act) f = i;
        ms[f] = '{int'(spawn_pos[15:8]), int'(spawn_pos[7:0]), int'(spawn_dir), int'(spawn_color), 1'b1};
        e_wr_en = 1; e_idx = f; e_data = rec(ms[f].x, ms[f].y, ms[f].c, 1'b1);
        e_ack = 1; m_spawn = 1;
      end
      e_busy = !((m_clear == 9) && (m_upd < 0) && !m_spawn);
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, e_busy);
    chk("active_cnt", active_cnt, n_act());
    chk("full", full, n_act() == 8);
    chk("spawn_ack", spawn_ack, e_ack);
    chk("frame_done", frame_done, e_fd);
    chk("overrun", overrun, e_ovr);
    chk("wr_en", wr_en, e_wr_en);
    if (e_wr_en || reset) begin
      chk("wr_index", wr_index, e_idx);
      chk("wr_data", wr_data, e_data);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic spawn(input logic [15:0] p, input logic [1:0] d, input logic [1:0] c,
                       output int idx, output logic [63:0] data);
    bit got;
    got = 0; idx = -1; data = '0;
    @(posedge clk); #1;
    spawn_req = 1'b1; spawn_pos = p; spawn_dir = d; spawn_color = c;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (spawn_ack) begin got = 1; idx = int'(wr_index); data = wr_data; end
    end
    if (!got) expire("spawn_ack");
    @(posedge clk); #1;
    spawn_req = 1'b0;
    spawn_pos = 16'($urandom); spawn_dir = 2'($urandom); spawn_color = 2'($urandom);
  endtask

  task automatic wait_write(input int idx, output logic [63:0] data);
    bit got;
    got = 0; data = '0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (wr_en && int'(wr_index) == idx) begin got = 1; data = wr_data; end
    end
    if (!got) expire("slot_write");
  endtask

  task automatic wait_fd(output int n);
    bit got;
    got = 0; n = 0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      n++;
      if (frame_done) got = 1;
    end
    if (!got) expire("frame_done");
  endtask

  task automatic wait_idle();
    bit got;
    got = 0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(negedge clk);
      if (!busy) got = 1;
    end
    if (!got) expire("clear_done");
  endtask

  // Holds spawn_req until ack, noting whether a frame_done came first.
  task automatic wait_ack_fd(output bit fd_first, output int idx, output logic [63:0] data);
    bit got, fd_seen;
    got = 0; fd_seen = 0; fd_first = 0; idx = -1; data = '0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (frame_done) fd_seen = 1;
      if (spawn_ack) begin got = 1; fd_first = fd_seen; idx = int'(wr_index); data = wr_data; end
    end
    if (!got) expire("held_spawn_ack");
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          idx, n;
    bit          fd_first;
    logic [63:0] data;
    logic [15:0] p;
    logic [1:0]  d;
    int          acks;

    reset = 1'b0; frame_tick = 1'b0; spawn_req = 1'b0;
    spawn_pos = '0; spawn_dir = '0; spawn_color = '0;
    #1 reset = 1'b1;

    // reset state and table clear
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b1);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_active_cnt", active_cnt, 4'd0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("clear_wr_en", wr_en, 1'b1);
      chk("clear_idx", wr_index, k);
      chk("clear_data", wr_data, 64'd0);
    end
    @(negedge clk);
    chk("clear_busy_low", busy, 1'b0);

    // first spawn
    spawn(16'h5050, 2'b00, 2'b01, idx, data);
    chk("spawn0_idx", idx, 0);
    chk("spawn0_data", data, 64'h0000_0005_0404_5050);
    @(negedge clk);
    chk("spawn0_cnt", active_cnt, 4'd1);

    // one frame: slot 0 moves down, frame_done 8 cycles after its write
    tick();
    wait_write(0, data);
    chk("move0_data", data, 64'h0000_0005_0404_5051);
    wait_fd(n);
    chk("frame_done_lat", n, 8);

    // left edge at x=0
    spawn(16'h0010, 2'b11, 2'b10, idx, data);
    chk("spawn1_idx", idx, 1);
    tick();
    wait_write(1, data);
    wait_fd(n);
`ifdef BULLET_CTRL_WRAP_EN
    chk("edge_wrap_data", data, 64'h0000_0006_0404_FF10);
    chk("edge_wrap_cnt", active_cnt, 4'd2);
`else
    chk("edge_kill_data", data, 64'h0000_0002_0404_0010);
    chk("edge_kill_cnt", active_cnt, 4'd1);
`endif

    // fill all eight slots; slot 5 sits at the bottom edge moving down
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      p = {8'h20 + 8'(i), 8'h40};
      d = 2'b10;
      if (i == 5) begin p = 16'h30FF; d = 2'b00; end
      spawn(p, d, 2'b01, idx, data);
      chk("fill_idx", idx, i);
    end
    @(negedge clk);
    chk("fill_full", full, 1'b1);
    chk("fill_cnt", active_cnt, 4'd8);

    @(posedge clk); #1;
    spawn_req = 1'b1; spawn_pos = 16'h7777; spawn_dir = 2'b01; spawn_color = 2'b10;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("held_no_ack", spawn_ack, 1'b0);
    end
    tick();
`ifdef BULLET_CTRL_WRAP_EN
    acks = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (spawn_ack) acks++;
    end
    chk("held_wrap_acks", acks, 0);
`else
    wait_ack_fd(fd_first, idx, data);
    chk("freed_idx", idx, 5);
    chk("freed_data", data, 64'h0000_0006_0404_7777);
    chk("freed_after_frame", fd_first, 1'b1);
`endif
    @(posedge clk); #1 spawn_req = 1'b0;

    // tick and spawn in the same cycle: frame pass wins
    pulse_reset();
    @(posedge clk); #1;
    spawn_req = 1'b1; spawn_pos = 16'h1234; spawn_dir = 2'b10; spawn_color = 2'b00; frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    wait_ack_fd(fd_first, idx, data);
    chk("coinc_after_frame", fd_first, 1'b1);
    chk("coinc_idx", idx, 0);
    chk("coinc_data", data, 64'h0000_0004_0404_1234);
    @(posedge clk); #1 spawn_req = 1'b0;

    // overrun: two further ticks while a pass is running
    @(negedge clk);
    chk("ovr_clear", overrun, 1'b0);
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(negedge clk);
    chk("ovr_set", overrun, 1'b1);
    wait_fd(n);
    wait_fd(n);
    chk("ovr_sticky", overrun, 1'b1);

    // asynchronous reset in the middle of a pass
    tick();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", wr_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b1);
    chk("mid_rst_cnt", active_cnt, 4'd0);
    chk("mid_rst_ovr", overrun, 1'b0);
    chk("mid_rst_data", wr_data, 64'd0);
    chk("mid_rst_idx", wr_index, 3'd0);
    chk("mid_rst_fd", frame_done, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_first", {wr_en, wr_index}, {1'b1, 3'd0});
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bullet_controller.md
BULLET_CONTROLLER -- requirements
Module: bullet_controller

Interface
REQ-001 SHALL have parameter NSLOT, default 8, number of bullet slots; the index width is 3 bits; only 8 is supported.
REQ-002 SHALL have parameter BSIZE, default 8'd4, width and height in pixels written for every bullet.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port frame_tick, input, 1, one-cycle pulse requesting a movement pass.
REQ-006 SHALL have port spawn_req, input, 1, held high until spawn_ack.
REQ-007 SHALL have port spawn_pos, input, 16, [15:8] x and [7:0] y.
REQ-008 SHALL have port spawn_dir, input, 2: 00 down (y+1), 01 up (y-1), 10 right (x+1), 11 left (x-1).
REQ-009 SHALL have port spawn_color, input, 2: 00 white, 01 green, 10 blue.
REQ-010 SHALL have port spawn_ack, output, 1, one-cycle acceptance pulse.
REQ-011 SHALL have port wr_en, output, 1, bullet table write strobe.
REQ-012 SHALL have port wr_index, output, 3, slot being written.
REQ-013 SHALL have port wr_data, output, 64, with [15:0] position, [23:16] and [31:24] BSIZE, [33:32] color, [34] render, and [63:35] zero.
REQ-014 SHALL have outputs busy (1), full (1), active_cnt (4), frame_done (1) and overrun (1).

Function
REQ-015 SHALL hold per slot: position (16), dir (2), color (2) and active (1).
REQ-016 SHALL use FSM states CLEAR, IDLE, SPAWN and UPDATE; busy is high in every state except IDLE.
REQ-017 CLEAR SHALL write slots 0..7, one per cycle, with all fields 0 (wr_en=1), then go to IDLE.
REQ-018 In IDLE, a frame_tick or a pending tick SHALL go to UPDATE, with priority over spawn_req.
REQ-019 In IDLE, spawn_req with full=0 SHALL latch the inputs into the lowest-index inactive slot and go to SPAWN.
REQ-020 SPAWN SHALL last 1 cycle: wr_en=1, render=1 for that slot, spawn_ack=1, then return to IDLE.
REQ-021 UPDATE SHALL visit slots 0..7 in 8 consecutive cycles; wr_en SHALL be 1 only for slots active on entry.
REQ-022 A moved slot SHALL be written with the new position and render=1.
REQ-023 A move that borrows below 0 or carries above 255 on the moving axis SHALL clear active, keep the old position and write render=0.
REQ-024 After slot 7, UPDATE SHALL pulse frame_done for 1 cycle and return to IDLE.
REQ-025 A frame_tick outside IDLE SHALL set a 1-deep pending flag; a tick while pending is set SHALL set overrun (sticky).
REQ-026 full SHALL equal (active_cnt==8); spawn_req while full SHALL be held without ack and SHALL NOT be dropped.
REQ-027 active_cnt SHALL update the cycle after each spawn or deactivation.
REQ-028 Spawn inputs SHALL be sampled only in the accepting cycle.

Reset
REQ-029 Reset SHALL, asynchronously and at any point (including mid-UPDATE), clear all slots, pending flag and overrun, and enter CLEAR.
REQ-030 During reset SHALL hold wr_en=0, spawn_ack=0, frame_done=0, active_cnt=0, full=0, busy=1, wr_index=0 and wr_data=0.
REQ-031 The first cycle after reset release SHALL write slot 0 in CLEAR.

Configuration
REQ-032 Macro BULLET_CTRL_WRAP_EN defined SHALL make REQ-023 wrap modulo 256 (0-1=255, 255+1=0) with the slot staying active.
REQ-033 Macro BULLET_CTRL_WRAP_EN undefined SHALL deactivate the slot per REQ-023.

Verification
REQ-034 Reset release -> 8 writes, idx 0..7, data 0, then busy=0 on cycle 9.
REQ-035 Spawn pos 16'h5050, dir 00, color 01 -> spawn_ack plus write idx 0, data 64'h0000_0005_0404_5050, active_cnt=1.
REQ-036 frame_tick with slot 0 at 16'h5050 dir 00 -> write idx0 position 16'h5051, frame_done 8 cycles later.
REQ-037 Slot at x=0, dir 11 plus tick -> write render=0, active_cnt decrements; with WRAP_EN -> x=255, render=1.
REQ-038 9 spawns -> 8 acks at idx 0..7, full=1, 9th held; a tick frees a slot -> 9th acked into that slot.
REQ-039 Two ticks during UPDATE -> overrun=1; tick coincident with spawn_req in IDLE -> UPDATE first, spawn after frame_done.
